// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and sample type used by the transmitter and receiver.
package i2s_pkg;

  localparam int unsigned I2S_WORD_BITS = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  localparam logic LR_LEFT  = 1'b1;
  localparam logic LR_RIGHT = 1'b0;

  typedef logic signed [I2S_WORD_BITS-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_shifter.sv
// Per-channel parallel-load, MSB-first shift register; o_msb is the bit to transmit next.
module i2s_tx_shifter #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/i2s_transmitter.sv
// Master-mode I2S transmitter: frame counter, one-pair holding buffer and load control
// feeding two channel shifters; lrclk=1 marks the left slot, data is delayed one sclk.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_BITS = I2S_WORD_BITS,
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic                        sclk,
  input  logic                        rst_n,
  input  logic signed [WORD_BITS-1:0] ldata,
  input  logic signed [WORD_BITS-1:0] rdata,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic                        mute_l,
  input  logic                        mute_r,
  output logic                        lrclk,
  output logic                        sdout,
  output logic                        frame_start,
  output logic                        underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_BITS);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_lrclk;
  logic                 r_sdout;
  logic                 r_frame_start;
  logic                 r_underrun;
  logic                 r_din_ready;
  logic [WORD_BITS-1:0] r_hold_l;
  logic [WORD_BITS-1:0] r_hold_r;

  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_pos;
  logic                 w_right;
  logic                 w_in_word;
  logic                 w_load;
  logic                 w_xfer;
  logic                 w_hold_full;
  logic                 w_have;
  logic                 w_shift_l;
  logic                 w_shift_r;
  logic                 w_msb_l;
  logic                 w_msb_r;
  logic                 w_sdout_nxt;
  logic [WORD_BITS-1:0] w_ld_l;
  logic [WORD_BITS-1:0] w_ld_r;

  // Slot decode is done on the next count so every output is a flop of that count.
  always_comb begin
    w_load      = (r_cnt == CNT_LAST);
    w_cnt_nxt   = w_load ? '0 : r_cnt + CNT_W'(1);
    w_right     = (w_cnt_nxt >= SLOT_C);
    w_pos       = w_right ? (w_cnt_nxt - SLOT_C) : w_cnt_nxt;
    w_in_word   = (w_pos >= CNT_W'(1)) && (w_pos <= WORD_C);
    w_shift_l   = w_in_word & ~w_right;
    w_shift_r   = w_in_word & w_right;
    w_sdout_nxt = 1'b0;
    if (w_shift_l) begin
      w_sdout_nxt = w_msb_l;
    end else if (w_shift_r) begin
      w_sdout_nxt = w_msb_r;
    end
  end

  // An empty holding buffer lets a pair offered at the load event bypass to the shifters.
  always_comb begin
    w_hold_full = ~r_din_ready;
    w_xfer      = din_valid & r_din_ready;
    w_have      = w_hold_full | din_valid;
    w_ld_l      = '0;
    w_ld_r      = '0;
    if (w_have && !mute_l) begin
      w_ld_l = w_hold_full ? r_hold_l : ldata;
    end
    if (w_have && !mute_r) begin
      w_ld_r = w_hold_full ? r_hold_r : rdata;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_lrclk       <= LR_LEFT;
      r_sdout       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_din_ready   <= 1'b1;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_lrclk       <= w_right ? LR_RIGHT : LR_LEFT;
      r_sdout       <= w_sdout_nxt;
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~w_have;
      if (w_load) begin
        r_din_ready <= 1'b1;
      end else if (w_xfer) begin
        r_din_ready <= 1'b0;
        r_hold_l    <= ldata;
        r_hold_r    <= rdata;
      end
    end
  end

  i2s_tx_shifter #(.WIDTH(WORD_BITS)) u_shift_l (
    .i_clk   (sclk),
    .i_rst_n (rst_n),
    .i_load  (w_load),
    .i_data  (w_ld_l),
    .i_shift (w_shift_l),
    .o_msb   (w_msb_l)
  );

  i2s_tx_shifter #(.WIDTH(WORD_BITS)) u_shift_r (
    .i_clk   (sclk),
    .i_rst_n (rst_n),
    .i_load  (w_load),
    .i_data  (w_ld_r),
    .i_shift (w_shift_r),
    .o_msb   (w_msb_r)
  );

  assign lrclk       = r_lrclk;
  assign sdout       = r_sdout;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign din_ready   = r_din_ready;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: frame scoreboard keyed by frame number, plus a serial receiver model.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int unsigned W = I2S_WORD_BITS;
  localparam int unsigned S = I2S_SLOT_BITS;
  localparam int unsigned F = 2 * S;

  logic    sclk = 1'b0;
  logic    rst_n = 1'b0;
  sample_t ldata = '0;
  sample_t rdata = '0;
  logic    din_valid = 1'b0;
  logic    mute_l = 1'b0;
  logic    mute_r = 1'b0;
  logic    din_ready;
  logic    lrclk;
  logic    sdout;
  logic    frame_start;
  logic    underrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           frame;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb_q[$];

  always #5 sclk = ~sclk;

  i2s_transmitter dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .ldata       (ldata),
    .rdata       (rdata),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .mute_l      (mute_l),
    .mute_r      (mute_r),
    .lrclk       (lrclk),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  // Reference frame position: count and frame number since reset.
  int m_cnt;
  int m_frame;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_frame <= 0;
    end else if (m_cnt == F - 1) begin
      m_cnt   <= 0;
      m_frame <= m_frame + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Frame monitor: per-cycle lrclk/frame_start/underrun checks, whole-frame compare at cnt F-1.
  logic [F-1:0] m_bits;
  logic [F-1:0] mon_exp;
  logic         mon_have;
  logic         mon_lr;
  exp_t         mon_e;
  always @(negedge sclk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_bits = '0;
    end else begin
      mon_have = (sb_q.size() > 0) && (sb_q[0].frame == m_frame);
      m_bits[m_cnt] = sdout;
      mon_lr = (m_cnt < S) ? LR_LEFT : LR_RIGHT;
      checks++;
      if (lrclk !== mon_lr) begin
        errors++;
        $display("FAIL lrclk frame=%0d cnt=%0d got=%b exp=%b", m_frame, m_cnt, lrclk, mon_lr);
      end
      checks++;
      if (frame_start !== (m_cnt == 0 && m_frame != 0)) begin
        errors++;
        $display("FAIL frame_start frame=%0d cnt=%0d got=%b", m_frame, m_cnt, frame_start);
      end
      checks++;
      if (underrun !== (m_cnt == 0 && m_frame != 0 && !mon_have)) begin
        errors++;
        $display("FAIL underrun frame=%0d cnt=%0d got=%b", m_frame, m_cnt, underrun);
      end
      if (m_cnt == F - 1) begin
        while (sb_q.size() > 0 && sb_q[0].frame < m_frame) begin
          mon_e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL frame_missed frame=%0d got=none exp=%h/%h", mon_e.frame, mon_e.l, mon_e.r);
        end
        mon_exp = '0;
        if (mon_have) begin
          mon_e = sb_q.pop_front();
          for (int i = 0; i < W; i++) begin
            mon_exp[1 + i]     = mon_e.l[W-1-i];
            mon_exp[S + 1 + i] = mon_e.r[W-1-i];
          end
        end
        checks++;
        if (m_bits !== mon_exp) begin
          errors++;
          $display("FAIL frame_data frame=%0d got=%h exp=%h", m_frame, m_bits, mon_exp);
        end
      end
    end
  end

  // Receiver model: slots framed by lrclk edges only, one-bit delay, MSB first.
  logic         rx_prev_lr;
  int           rx_idx;
  logic [W-1:0] rx_sr;
  logic [W-1:0] rx_l = '0;
  logic [W-1:0] rx_r = '0;
  always @(negedge sclk) begin
    if (!rst_n) begin
      rx_prev_lr = LR_LEFT;
      rx_idx     = -1;
      rx_sr      = '0;
    end else begin
      if (lrclk !== rx_prev_lr) begin
        if (lrclk == LR_RIGHT) rx_l = rx_sr;
        else rx_r = rx_sr;
        rx_idx = 0;
        rx_sr  = '0;
      end else begin
        rx_idx++;
      end
      if (rx_idx >= 1 && rx_idx <= W) rx_sr = {rx_sr[W-2:0], sdout};
      rx_prev_lr = lrclk;
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (m_cnt != c) begin
      tick;
      n++;
      if (n > 2 * F) begin
        checks++;
        errors++;
        $display("FAIL wait_cnt timeout got=%0d exp=%0d", m_cnt, c);
        return;
      end
    end
  endtask

  task automatic wait_frame(input int f, input int c);
    int n = 0;
    while (!(m_frame == f && m_cnt == c)) begin
      tick;
      n++;
      if (n > 8 * F) begin
        checks++;
        errors++;
        $display("FAIL wait_frame timeout got=%0d/%0d exp=%0d/%0d", m_frame, m_cnt, f, c);
        return;
      end
    end
  endtask

  task automatic push_exp(input int f, input logic [W-1:0] l, input logic [W-1:0] r);
    exp_t e;
    e.frame = f;
    e.l     = l;
    e.r     = r;
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    checks += 5;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL rst_lrclk got=%b exp=1", lrclk); end
    if (sdout !== 1'b0) begin errors++; $display("FAIL rst_sdout got=%b exp=0", sdout); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_din_ready got=%b exp=1", din_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int f;
    wait_cnt(5);
    f = m_frame;
    ldata = 24'hA5F00F;
    rdata = 24'h123456;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", din_ready); end
    push_exp(f + 1, 24'hA5F00F, 24'h123456);
    tick;
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", din_ready); end
    wait_cnt(F - 1);
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_last got=%b exp=0", din_ready); end
    tick;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_load got=%b exp=1", din_ready); end
    tick;
    checks++;
    if (sdout !== 1'b1) begin errors++; $display("FAIL basic_left_msb got=%b exp=1", sdout); end
    wait_frame(f + 2, 0);
  endtask

  task automatic test_underrun;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse got=%b exp=1", underrun); end
    tick;
    checks += 2;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width got=%b exp=0", underrun); end
    if (sdout !== 1'b0) begin errors++; $display("FAIL underrun_repeat got=%b exp=0", sdout); end
  endtask

  task automatic test_bypass;
    int f;
    wait_cnt(F - 1);
    f = m_frame;
    ldata = 24'h3C3C3C;
    rdata = 24'hC3C3C3;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got=%b exp=1", din_ready); end
    push_exp(f + 1, 24'h3C3C3C, 24'hC3C3C3);
    tick;
    din_valid = 1'b0;
    checks += 2;
    if (underrun !== 1'b0) begin errors++; $display("FAIL bypass_underrun got=%b exp=0", underrun); end
    if (din_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready_after got=%b exp=1", din_ready); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] val;
    logic         exp_rdy;
    tick;
    wait_cnt(0);
    val = 24'h100000;
    din_valid = 1'b1;
    for (int cyc = 0; cyc < 4 * F; cyc++) begin
      ldata = val;
      rdata = ~val;
      exp_rdy = (m_cnt == 0);
      checks++;
      if (din_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready cnt=%0d got=%b exp=%b", m_cnt, din_ready, exp_rdy);
      end
      if (exp_rdy) begin
        push_exp(m_frame + 1, val, ~val);
        val = val + 24'd1;
      end
      tick;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_mute;
    int f;
    wait_cnt(5);
    f = m_frame;
    mute_l = 1'b1;
    mute_r = 1'b0;
    ldata = 24'h7FFFFF;
    rdata = 24'h800000;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL mute_ready got=%b exp=1", din_ready); end
    push_exp(f + 1, 24'h000000, 24'h800000);
    tick;
    din_valid = 1'b0;
    wait_frame(f + 1, 5);
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL mute_ready2 got=%b exp=1", din_ready); end
    push_exp(f + 2, 24'h7FFFFF, 24'h000000);
    tick;
    din_valid = 1'b0;
    wait_cnt(S + 1);
    checks++;
    if (sdout !== 1'b1) begin errors++; $display("FAIL mute_right_msb got=%b exp=1", sdout); end
    wait_cnt(40);
    mute_l = 1'b0;
    mute_r = 1'b1;
    wait_frame(f + 2, 0);
    mute_r = 1'b0;
    tick;
    tick;
    checks++;
    if (sdout !== 1'b1) begin errors++; $display("FAIL mute_left_bit22 got=%b exp=1", sdout); end
    wait_frame(f + 3, 0);
  endtask

  task automatic test_reset_mid;
    int f;
    wait_cnt(5);
    f = m_frame;
    ldata = 24'h5A5A5A;
    rdata = 24'hA5A5A5;
    din_valid = 1'b1;
    push_exp(f + 1, 24'h5A5A5A, 24'hA5A5A5);
    tick;
    din_valid = 1'b0;
    wait_frame(f + 1, 5);
    ldata = 24'h111111;
    rdata = 24'h222222;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got=%b exp=0", din_ready); end
    wait_cnt(20);
    checks++;
    if (sdout !== 1'b1) begin errors++; $display("FAIL mid_bit4 got=%b exp=1", sdout); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL mid_lrclk got=%b exp=1", lrclk); end
    if (sdout !== 1'b0) begin errors++; $display("FAIL mid_sdout got=%b exp=0", sdout); end
    if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_din_ready got=%b exp=1", din_ready); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_frame_start got=%b exp=0", frame_start); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun got=%b exp=0", underrun); end
    repeat (3) tick;
    rst_n = 1'b1;
  endtask

  task automatic test_loopback;
    wait_cnt(5);
    ldata = 24'h9ABCDE;
    rdata = 24'h0F1E2D;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL loop_ready got=%b exp=1", din_ready); end
    push_exp(m_frame + 1, 24'h9ABCDE, 24'h0F1E2D);
    tick;
    din_valid = 1'b0;
    wait_frame(2, 0);
    @(negedge sclk);
    #1;
    checks += 2;
    if (rx_l !== 24'h9ABCDE) begin errors++; $display("FAIL loop_left got=%h exp=9abcde", rx_l); end
    if (rx_r !== 24'h0F1E2D) begin errors++; $display("FAIL loop_right got=%h exp=0f1e2d", rx_r); end
    wait_frame(3, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_bypass();
    test_back_to_back();
    test_mute();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
